ysyx_24110015_axi4_burst_rd_slave: RTL and testbench
====================================================

Name: ysyx_24110015_axi4_burst_rd_slave

Overview:
AXI4 read-only burst responder: accepts AR requests, generates per-beat word addresses for FIXED/INCR/WRAP bursts, fetches each beat from a variable-latency word memory port and returns R beats. Serves as the device end of the core's AXI4 master read path, e.g. a boot ROM or flash model behind the SoC bus. One burst outstanding at a time.

Parameters:
ADDR_W, 32, address width (data fixed at 32 bits).
ID_W, 4, AXI ID width.

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous reset, active-low
axi_arvalid  in  1  AR valid
axi_arready  out  1  AR ready
axi_araddr  in  ADDR_W  burst start byte address
axi_arid  in  ID_W  transaction ID
axi_arlen  in  8  beats minus 1
axi_arsize  in  3  log2 bytes per beat
axi_arburst  in  2  0 FIXED, 1 INCR, 2 WRAP
axi_rvalid  out  1  R valid
axi_rready  in  1  R ready
axi_rdata  out  32  read data, full word
axi_rresp  out  2  00 OKAY, 10 SLVERR
axi_rlast  out  1  final beat
axi_rid  out  ID_W  echoed arid
mem_req  out  1  word fetch request, held until mem_rvalid
mem_addr  out  ADDR_W  word-aligned fetch address (bits [1:0]=0)
mem_rvalid  in  1  fetch done, 1-cycle pulse
mem_rdata  in  32  fetched word, valid with mem_rvalid

Behaviour:
- Reset (async, reset_n=0): state IDLE; arready, rvalid, rlast, mem_req = 0; rdata, rresp, rid, mem_addr = 0. arready rises at the first clock edge after reset release.
- States IDLE, FETCH, RESP. All outputs registered.
- IDLE: arready=1. On arvalid&arready: latch id, addr, len, size, burst; beat=0; arready=0; error check; next FETCH (OK) or RESP (error).
- Error burst when arsize>2, arburst==3, WRAP with arlen not in {1,3,7,15}, or araddr not aligned to 1<<arsize. Returns arlen+1 beats, rresp=10, rdata=0, no mem_req issued.
- FETCH: mem_req=1, mem_addr={cur_addr[ADDR_W-1:2],2'b00}. mem_rvalid may arrive in any cycle mem_req is high, including its first. On mem_rvalid: capture mem_rdata into rdata, rresp=00, mem_req=0, next RESP. mem_rvalid while mem_req=0 ignored.
- RESP: rvalid=1, rlast=(beat==len), rid=latched id. rdata/rresp/rid/rlast held stable while rvalid&!rready. On rready: rvalid=0. If last, go IDLE with arready=1 next cycle. Else beat+1, advance address, go FETCH (OK) or stay in RESP with next error beat asserted the following cycle.
- Min latency: AR handshake at edge E0, mem_rvalid in cycle after E0, rvalid high after E1. Per-beat throughput for zero-wait memory: one beat every 2 cycles.
- Address advance with inc=1<<size. FIXED: unchanged. INCR: addr+inc, modulo 2^ADDR_W, no 4KB check (master's duty). WRAP: mask=((len+1)<<size)-1, addr=(addr&~mask)|((addr+inc)&mask).
- Narrow beats: whole word returned; master selects lanes by address.
- arlen=255 INCR fully supported (8-bit beat counter, no overflow since beat<=len).
- Reset mid-burst: burst abandoned, mem_req drops immediately (async); memory side must tolerate an aborted request.

Decomposition:
- Package ysyx_24110015_axi_pkg: burst encodings (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR), state enum, ID_W default.
- Sub-module ysyx_24110015_axi_burst_addr: combinational next-address generator (addr, size, len, burst -> next addr), reusable for a future write responder.

Test Plan:
- INCR arlen=3 size=2 addr 0x100, mem 1-cycle -> mem_addr 0x100,0x104,0x108,0x10C; 4 beats OKAY, rlast on 4th only, rid echoed.
- WRAP arlen=3 size=2 addr 0x10C -> fetch order 0x10C,0x100,0x104,0x108.
- FIXED arlen=2 addr 0x20, mem_rvalid delayed 5 cycles, rready low 3 cycles on beat 1 -> three fetches of 0x20, R signals held stable while stalled.
- Errors: arsize=3 / arburst=3 / WRAP arlen=2 / addr 0x102 size=2 -> arlen+1 beats rresp=10, rdata=0, mem_req never high.
- INCR arlen=255 size=0 addr 0xFFFFFFF0 -> 256 beats, mem_addr wraps through 0x00000000, single rlast.
- reset_n pulsed low during FETCH of beat 2 -> mem_req/rvalid drop immediately; after release arready=1 and a new burst completes normally.

Source files
------------

// File: rtl/ysyx_24110015_axi_pkg.sv
// Shared definitions for the AXI4 burst read responder: burst and response
// encodings, responder FSM states and the request legality check.
package ysyx_24110015_axi_pkg;

  localparam int ID_W_DEF = 4;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // A request is refused (answered with SLVERR beats) when it asks for more
  // than a word per beat, uses the reserved burst type, wraps over a span
  // that is not 2/4/8/16 beats, or starts off its beat-size alignment.
  function automatic logic burst_err(input logic [1:0] addr_lo,
                                     input logic [7:0] len,
                                     input logic [2:0] size,
                                     input logic [1:0] burst);
    logic err_v;
    logic misalign_v;
    logic wrap_len_bad_v;
    case (size)
      3'd0:    misalign_v = 1'b0;
      3'd1:    misalign_v = addr_lo[0];
      3'd2:    misalign_v = (addr_lo != 2'b00);
      default: misalign_v = 1'b0;
    endcase
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: wrap_len_bad_v = 1'b0;
      default:                 wrap_len_bad_v = 1'b1;
    endcase
    if (size > 3'd2) begin
      err_v = 1'b1;
    end else if (burst == 2'd3) begin
      err_v = 1'b1;
    end else if ((burst == BURST_WRAP) && wrap_len_bad_v) begin
      err_v = 1'b1;
    end else begin
      err_v = misalign_v;
    end
    return err_v;
  endfunction

endpackage

// File: rtl/ysyx_24110015_axi_burst_addr.sv
// Combinational next-beat address generator for AXI4 FIXED/INCR/WRAP bursts.
// Kept free of any read/write specifics so a write responder can reuse it.
module ysyx_24110015_axi_burst_addr
  import ysyx_24110015_axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] one_s;
  logic [ADDR_W-1:0] inc_s;
  logic [ADDR_W-1:0] sum_s;
  logic [ADDR_W-1:0] span_s;
  logic [ADDR_W-1:0] mask_s;

  // Step the address by one beat; WRAP keeps the upper bits of the wrap window
  // and lets only the in-window offset roll over.
  always_comb begin
    one_s  = {{(ADDR_W-1){1'b0}}, 1'b1};
    inc_s  = one_s << size;
    sum_s  = addr + inc_s;
    span_s = ({{(ADDR_W-8){1'b0}}, len} + one_s) << size;
    mask_s = span_s - one_s;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = sum_s;
      BURST_WRAP:  next_addr = (addr & ~mask_s) | (sum_s & mask_s);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_axi4_burst_rd_slave.sv
// AXI4 read-only burst responder. Accepts one AR request at a time, walks the
// burst beat by beat, fetches each word from a variable-latency memory port
// and returns it on R. Illegal requests are answered with SLVERR beats
// without touching memory.
module ysyx_24110015_axi4_burst_rd_slave
  import ysyx_24110015_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic [ID_W-1:0]   axi_arid,
  input  logic [7:0]        axi_arlen,
  input  logic [2:0]        axi_arsize,
  input  logic [1:0]        axi_arburst,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [31:0]       axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rlast,
  output logic [ID_W-1:0]   axi_rid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  state_t            state_r,    state_s;
  logic              arready_r,  arready_s;
  logic              rvalid_r,   rvalid_s;
  logic              rlast_r,    rlast_s;
  logic [31:0]       rdata_r,    rdata_s;
  logic [1:0]        rresp_r,    rresp_s;
  logic [ID_W-1:0]   rid_r,      rid_s;
  logic              mem_req_r,  mem_req_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;

  // Latched burst context
  logic [ID_W-1:0]   id_r,    id_s;
  logic [ADDR_W-1:0] addr_r,  addr_s;
  logic [7:0]        len_r,   len_s;
  logic [2:0]        size_r,  size_s;
  logic [1:0]        burst_r, burst_s;
  logic              err_r,   err_s;
  logic [7:0]        beat_r,  beat_s;

  logic [ADDR_W-1:0] next_addr_s;
  logic              ar_err_s;
  logic [7:0]        beat_inc_s;

  ysyx_24110015_axi_burst_addr #(
    .ADDR_W (ADDR_W)
  ) u_burst_addr (
    .addr      (addr_r),
    .size      (size_r),
    .len       (len_r),
    .burst     (burst_r),
    .next_addr (next_addr_s)
  );

  // Next-state and next-output logic; every output is computed here one
  // cycle ahead and registered below.
  always_comb begin
    state_s    = state_r;
    arready_s  = arready_r;
    rvalid_s   = rvalid_r;
    rlast_s    = rlast_r;
    rdata_s    = rdata_r;
    rresp_s    = rresp_r;
    rid_s      = rid_r;
    mem_req_s  = mem_req_r;
    mem_addr_s = mem_addr_r;
    id_s       = id_r;
    addr_s     = addr_r;
    len_s      = len_r;
    size_s     = size_r;
    burst_s    = burst_r;
    err_s      = err_r;
    beat_s     = beat_r;
    ar_err_s   = burst_err(axi_araddr[1:0], axi_arlen, axi_arsize, axi_arburst);
    beat_inc_s = beat_r + 8'd1;

    case (state_r)
      ST_IDLE: begin
        arready_s = 1'b1;
        if (axi_arvalid && arready_r) begin
          arready_s = 1'b0;
          id_s      = axi_arid;
          addr_s    = axi_araddr;
          len_s     = axi_arlen;
          size_s    = axi_arsize;
          burst_s   = axi_arburst;
          err_s     = ar_err_s;
          beat_s    = 8'd0;
          if (ar_err_s) begin
            state_s  = ST_RESP;
            rvalid_s = 1'b1;
            rlast_s  = (axi_arlen == 8'd0);
            rdata_s  = 32'd0;
            rresp_s  = RESP_SLVERR;
            rid_s    = axi_arid;
          end else begin
            state_s    = ST_FETCH;
            mem_req_s  = 1'b1;
            mem_addr_s = {axi_araddr[ADDR_W-1:2], 2'b00};
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (mem_rvalid) begin
          mem_req_s = 1'b0;
          rvalid_s  = 1'b1;
          rdata_s   = mem_rdata;
          rresp_s   = RESP_OKAY;
          rlast_s   = (beat_r == len_r);
          rid_s     = id_r;
          state_s   = ST_RESP;
        end else begin
          mem_req_s = 1'b1;
          state_s   = ST_FETCH;
        end
      end

      ST_RESP: begin
        if (rvalid_r) begin
          if (axi_rready) begin
            rvalid_s = 1'b0;
            rlast_s  = 1'b0;
            if (rlast_r) begin
              state_s   = ST_IDLE;
              arready_s = 1'b1;
            end else begin
              beat_s = beat_inc_s;
              addr_s = next_addr_s;
              if (err_r) begin
                // Error bursts stay here; the next SLVERR beat is raised
                // by the !rvalid branch on the following cycle.
                state_s = ST_RESP;
              end else begin
                state_s    = ST_FETCH;
                mem_req_s  = 1'b1;
                mem_addr_s = {next_addr_s[ADDR_W-1:2], 2'b00};
              end
            end
          end else begin
            state_s = ST_RESP;
          end
        end else begin
          rvalid_s = 1'b1;
          rlast_s  = (beat_r == len_r);
          rdata_s  = 32'd0;
          rresp_s  = RESP_SLVERR;
          rid_s    = id_r;
          state_s  = ST_RESP;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
        rlast_s   = 1'b0;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State, output and burst-context registers; reset abandons any burst.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rlast_r    <= 1'b0;
      rdata_r    <= 32'd0;
      rresp_r    <= 2'b00;
      rid_r      <= {ID_W{1'b0}};
      mem_req_r  <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      id_r       <= {ID_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      len_r      <= 8'd0;
      size_r     <= 3'd0;
      burst_r    <= 2'd0;
      err_r      <= 1'b0;
      beat_r     <= 8'd0;
    end else begin
      state_r    <= state_s;
      arready_r  <= arready_s;
      rvalid_r   <= rvalid_s;
      rlast_r    <= rlast_s;
      rdata_r    <= rdata_s;
      rresp_r    <= rresp_s;
      rid_r      <= rid_s;
      mem_req_r  <= mem_req_s;
      mem_addr_r <= mem_addr_s;
      id_r       <= id_s;
      addr_r     <= addr_s;
      len_r      <= len_s;
      size_r     <= size_s;
      burst_r    <= burst_s;
      err_r      <= err_s;
      beat_r     <= beat_s;
    end
  end

  assign axi_arready = arready_r;
  assign axi_rvalid  = rvalid_r;
  assign axi_rlast   = rlast_r;
  assign axi_rdata   = rdata_r;
  assign axi_rresp   = rresp_r;
  assign axi_rid     = rid_r;
  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;

endmodule

// File: tb/tb_ysyx_24110015_axi4_burst_rd_slave.sv
// Directed scoreboard bench for the AXI4 burst read responder. Expected fetch
// addresses and R beats are queued when a request is issued and popped as the
// DUT produces memory requests and R beats.
module tb_ysyx_24110015_axi4_burst_rd_slave;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic        clock;
  logic        reset_n;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic [3:0]  axi_rid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int mem_lat = 0;

  logic [31:0] fetch_q[$];
  beat_t       exp_q[$];

  logic [31:0] m_addr;
  logic [31:0] m_exp;
  int          m_wait;
  bit          m_abort;

  ysyx_24110015_axi4_burst_rd_slave dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_araddr  (axi_araddr),
    .axi_arid    (axi_arid),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rid     (axi_rid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model: checks each request address and answers after mem_lat cycles.
  initial begin : mem_model
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      @(posedge clock); #1;
      if (mem_req === 1'b1) begin
        m_addr = mem_addr;
        m_exp  = (fetch_q.size() > 0) ? fetch_q.pop_front() : 32'hFFFF_FFFF;
        chk("mem_addr", m_addr, m_exp);
        m_wait  = mem_lat;
        m_abort = 1'b0;
        while (m_wait > 0 && !m_abort) begin
          @(posedge clock); #1;
          if (mem_req !== 1'b1) m_abort = 1'b1;
          m_wait--;
        end
        if (!m_abort) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memf(m_addr);
          @(posedge clock); #1;
          mem_rvalid = 1'b0;
          mem_rdata  = 32'd0;
        end
      end
    end
  end

  task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] id);
    bit          err;
    logic [31:0] a, inc, span, bnd, fa;
    beat_t       b;
    int          guard;
    inc  = 32'd1 << size;
    err  = (size > 3'd2) || (burst == 2'd3) ||
           (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
           ((addr & (inc - 32'd1)) != 32'd0);
    span = (32'(len) + 32'd1) * inc;
    bnd  = (addr / span) * span;
    a    = addr;
    for (int i = 0; i <= int'(len); i++) begin
      fa     = {a[31:2], 2'b00};
      b.last = (i == int'(len));
      b.id   = id;
      if (err) begin
        b.data = 32'd0;
        b.resp = 2'b10;
      end else begin
        fetch_q.push_back(fa);
        b.data = memf(fa);
        b.resp = 2'b00;
      end
      exp_q.push_back(b);
      if (burst == 2'd1) begin
        a = a + inc;
      end else if (burst == 2'd2) begin
        a = a + inc;
        if (a >= bnd + span) a = bnd;
      end
    end
    axi_araddr  = addr;
    axi_arlen   = len;
    axi_arsize  = size;
    axi_arburst = burst;
    axi_arid    = id;
    axi_arvalid = 1'b1;
    guard = 0;
    while (axi_arready !== 1'b1 && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("arready_seen", {31'd0, axi_arready}, 32'd1);
    @(posedge clock); #1;
    axi_arvalid = 1'b0;
  endtask

  task automatic collect(input int nbeats, input int stall_beat, input int stall_cyc, input bit full);
    int    got, guard, stall_left;
    beat_t e, snap;
    got = 0;
    guard = 0;
    stall_left = stall_cyc;
    snap = '0;
    axi_rready = 1'b0;
    while (got < nbeats && guard < nbeats * 40 + 100) begin
      @(posedge clock); #1;
      guard++;
      if (axi_rvalid === 1'b1) begin
        if (got == stall_beat && stall_left > 0) begin
          if (stall_left == stall_cyc) begin
            snap = '{axi_rdata, axi_rresp, axi_rlast, axi_rid};
          end else begin
            chk("stall_rdata", axi_rdata, snap.data);
            chk("stall_rresp", {30'd0, axi_rresp}, {30'd0, snap.resp});
            chk("stall_rlast", {31'd0, axi_rlast}, {31'd0, snap.last});
            chk("stall_rid", {28'd0, axi_rid}, {28'd0, snap.id});
          end
          stall_left--;
          axi_rready = 1'b0;
        end else begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '{32'hBAD0_BAD0, 2'b11, 1'b0, 4'h0};
          chk("rdata", axi_rdata, e.data);
          chk("rresp", {30'd0, axi_rresp}, {30'd0, e.resp});
          chk("rlast", {31'd0, axi_rlast}, {31'd0, e.last});
          chk("rid", {28'd0, axi_rid}, {28'd0, e.id});
          got++;
          axi_rready = 1'b1;
        end
      end else begin
        axi_rready = 1'b0;
      end
    end
    chk("beats_received", 32'(got), 32'(nbeats));
    @(posedge clock); #1;
    axi_rready = 1'b0;
    if (full) begin
      chk("arready_after_burst", {31'd0, axi_arready}, 32'd1);
      chk("rvalid_after_burst", {31'd0, axi_rvalid}, 32'd0);
    end
  endtask

  initial begin : stim
    int guard;
    reset_n     = 1'b1;
    axi_arvalid = 1'b0;
    axi_araddr  = 32'd0;
    axi_arid    = 4'd0;
    axi_arlen   = 8'd0;
    axi_arsize  = 3'd0;
    axi_arburst = 2'd0;
    axi_rready  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_arready", {31'd0, axi_arready}, 32'd0);
    chk("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    chk("rst_rlast", {31'd0, axi_rlast}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rdata", axi_rdata, 32'd0);
    chk("rst_rresp", {30'd0, axi_rresp}, 32'd0);
    chk("rst_rid", {28'd0, axi_rid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset_n = 1'b1;
    chk("arready_at_release", {31'd0, axi_arready}, 32'd0);
    @(posedge clock); #1;
    chk("arready_first_edge", {31'd0, axi_arready}, 32'd1);

    // INCR 4 beats, single-cycle memory
    mem_lat = 0;
    issue_ar(32'h0000_0100, 8'd3, 3'd2, 2'd1, 4'h5);
    collect(4, -1, 0, 1'b1);

    // WRAP 4 beats starting mid-window
    issue_ar(32'h0000_010C, 8'd3, 3'd2, 2'd2, 4'hA);
    collect(4, -1, 0, 1'b1);

    // FIXED 3 beats, slow memory, master stall on beat 1
    mem_lat = 5;
    issue_ar(32'h0000_0020, 8'd2, 3'd2, 2'd0, 4'h3);
    collect(3, 1, 3, 1'b1);
    mem_lat = 0;

    // Error bursts: oversize, reserved burst, bad wrap length, misaligned
    issue_ar(32'h0000_0040, 8'd1, 3'd3, 2'd1, 4'h1);
    collect(2, -1, 0, 1'b1);
    issue_ar(32'h0000_0040, 8'd0, 3'd2, 2'd3, 4'h2);
    collect(1, -1, 0, 1'b1);
    issue_ar(32'h0000_0040, 8'd2, 3'd2, 2'd2, 4'h4);
    collect(3, 0, 2, 1'b1);
    issue_ar(32'h0000_0102, 8'd1, 3'd2, 2'd1, 4'h6);
    collect(2, -1, 0, 1'b1);

    // Longest INCR burst, byte beats, crossing the top of the address space
    issue_ar(32'hFFFF_FFF0, 8'd255, 3'd0, 2'd1, 4'hF);
    collect(256, -1, 0, 1'b1);

    // Reset while beat 2 is being fetched
    mem_lat = 10;
    issue_ar(32'h0000_0200, 8'd3, 3'd2, 2'd1, 4'h9);
    collect(2, -1, 0, 1'b0);
    guard = 0;
    while (mem_req !== 1'b1 && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("mem_req_before_reset", {31'd0, mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_rvalid", {31'd0, axi_rvalid}, 32'd0);
    chk("abort_arready", {31'd0, axi_arready}, 32'd0);
    fetch_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("arready_after_abort", {31'd0, axi_arready}, 32'd1);
    mem_lat = 1;
    issue_ar(32'h0000_0300, 8'd1, 3'd2, 2'd1, 4'h7);
    collect(2, -1, 0, 1'b1);

    repeat (5) @(posedge clock);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("fetch_q_empty", 32'(fetch_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
